an_encoder_seq: RTL and testbench



---
 rtl/an_code_pkg.sv | 21 ++
 rtl/an_err_inject.sv | 46 ++++
 rtl/an_encoder_seq.sv | 111 +++++++++++
 tb/tb_an_encoder_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/an_code_pkg.sv
// Shared AN-code constants (A=37, 12-bit data, 18-bit codeword) and the
// encoder state type; the downstream decoder imports the same package.
package an_code_pkg;

  localparam int unsigned N_W    = 12;
  localparam int unsigned A      = 37;
  localparam int unsigned A_W    = 6;
  localparam int unsigned CODE_W = N_W + A_W;
  localparam int unsigned BIT_W  = 5;
  localparam int unsigned K_W    = $clog2(A_W);

  localparam logic [A_W-1:0] A_VEC = A_W'(A);

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StInj,
    StOut
  } enc_state_e;

endpackage

// File: rtl/an_err_inject.sv
// Combinational single-arithmetic-error injector: adds or subtracts 2^bit to
// a codeword, skipping the injection when the result would leave [0, 2^CODE_W).
module an_err_inject
  import an_code_pkg::*;
(
  input  logic [CODE_W-1:0] acc_i,
  input  logic              inj_en_i,
  input  logic              inj_neg_i,
  input  logic [BIT_W-1:0]  inj_bit_i,
  output logic [CODE_W-1:0] code_o,
  output logic              skipped_o
);

  logic [CODE_W:0] pow;
  logic [CODE_W:0] sum;

  always_comb begin
    code_o    = acc_i;
    skipped_o = 1'b0;
    pow       = '0;
    sum       = '0;
    if (inj_en_i) begin
      if (inj_bit_i >= BIT_W'(CODE_W)) begin
        skipped_o = 1'b1;
      end else begin
        pow = (CODE_W + 1)'(1) << inj_bit_i;
        if (inj_neg_i) begin
          // Negative codewords are not representable.
          if ({1'b0, acc_i} >= pow) begin
            code_o = acc_i - pow[CODE_W-1:0];
          end else begin
            skipped_o = 1'b1;
          end
        end else begin
          sum = {1'b0, acc_i} + pow;
          if (sum[CODE_W]) begin
            skipped_o = 1'b1;
          end else begin
            code_o = sum[CODE_W-1:0];
          end
        end
      end
    end
  end

endmodule

// File: rtl/an_encoder_seq.sv
// Sequential AN encoder: N*A by shift-and-add over A_W cycles, optional
// single arithmetic error, codeword presented with a valid/ready handshake.
module an_encoder_seq
  import an_code_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N_W-1:0]    in_n_i,
  input  logic              inj_en_i,
  input  logic              inj_neg_i,
  input  logic [BIT_W-1:0]  inj_bit_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CODE_W-1:0] out_code_o,
  output logic              out_inj_skipped_o
);

  enc_state_e        state_q, state_d;
  logic [N_W-1:0]    n_q;
  logic              en_q, neg_q;
  logic [BIT_W-1:0]  bit_q;
  logic [CODE_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [CODE_W-1:0] code_q;
  logic              skip_q;
  logic              load;
  logic [CODE_W-1:0] n_ext;
  logic [CODE_W-1:0] code_inj;
  logic              skip_inj;

  assign n_ext = CODE_W'(n_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          load    = 1'b1;
          acc_d   = '0;
          k_d     = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        // Fixed A_W iterations regardless of the popcount of A.
        if (A_VEC[k_q]) begin
          acc_d = acc_q + (n_ext << k_q);
        end
        k_d = k_q + K_W'(1);
        if (k_q == K_W'(A_W - 1)) begin
          state_d = StInj;
        end
      end
      StInj: state_d = StOut;
      StOut: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  an_err_inject u_inject (
    .acc_i     (acc_q),
    .inj_en_i  (en_q),
    .inj_neg_i (neg_q),
    .inj_bit_i (bit_q),
    .code_o    (code_inj),
    .skipped_o (skip_inj)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      en_q    <= 1'b0;
      neg_q   <= 1'b0;
      bit_q   <= '0;
      code_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      if (load) begin
        n_q   <= in_n_i;
        en_q  <= inj_en_i;
        neg_q <= inj_neg_i;
        bit_q <= inj_bit_i;
      end
      if (state_q == StInj) begin
        code_q <= code_inj;
        skip_q <= skip_inj;
      end
    end
  end

  assign in_ready_o        = (state_q == StIdle);
  assign out_valid_o       = (state_q == StOut);
  assign out_code_o        = code_q;
  assign out_inj_skipped_o = skip_q;

endmodule

// File: tb/tb_an_encoder_seq.sv
// Scoreboard bench for an_encoder_seq: the driver pushes model results at
// accept, a monitor compares whenever out_valid is presented.
module tb_an_encoder_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_n;
  logic        inj_en;
  logic        inj_neg;
  logic [4:0]  inj_bit;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_code;
  logic        out_inj_skipped;

  an_encoder_seq dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .in_n_i            (in_n),
    .inj_en_i          (inj_en),
    .inj_neg_i         (inj_neg),
    .inj_bit_i         (inj_bit),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .out_code_o        (out_code),
    .out_inj_skipped_o (out_inj_skipped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int skip;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_accept = -100;
  bit   b2b_chk  = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   prev_v   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: product N*37, then the single-error rules on plain integers.
  function automatic exp_t model(input int n, input bit en, input bit neg, input int b);
    exp_t e;
    int   v;
    v      = n * 37;
    e.code = v;
    e.skip = 0;
    if (en) begin
      if (b >= 18) e.skip = 1;
      else if (neg) begin
        if (v >= (1 << b)) e.code = v - (1 << b);
        else e.skip = 1;
      end else begin
        if (v + (1 << b) <= 262143) e.code = v + (1 << b);
        else e.skip = 1;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_v) check("latency", cyc - last_accept, 7);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_code", int'(out_code), q[0].code);
          check("out_skipped", int'(out_inj_skipped), q[0].skip);
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_v = out_valid;
    end else begin
      prev_v = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int n, input bit en, input bit neg, input int b);
    int w;
    int prev;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 300) begin
      in_n    = 12'($urandom);
      inj_en  = 1'($urandom);
      inj_neg = 1'($urandom);
      inj_bit = 5'($urandom);
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_n     = 12'(n);
    inj_en   = en;
    inj_neg  = neg;
    inj_bit  = 5'(b);
    q.push_back(model(n, en, neg, b));
    prev        = last_accept;
    last_accept = cyc + 1;
    if (b2b_chk) check("issue_interval", last_accept - prev, 9);
    @(negedge clk);
    check("in_ready_busy", int'(in_ready), 0);
  endtask

  task automatic drain();
    int w;
    in_valid = 1'b0;
    w = 0;
    while ((q.size() != 0 || out_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain", q.size(), 0);
  endtask

  int dn[9]  = '{564, 564, 564, 564, 564, 564, 4095, 0, 564};
  bit den[9] = '{0, 1, 1, 1, 1, 1, 1, 1, 1};
  bit dng[9] = '{0, 0, 0, 1, 1, 1, 0, 1, 0};
  int db[9]  = '{0, 0, 17, 14, 3, 15, 17, 0, 20};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_n      = '0;
    inj_en    = 1'b0;
    inj_neg   = 1'b0;
    inj_bit   = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_code", int'(out_code), 0);
    check("rst_skipped", int'(out_inj_skipped), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      send(dn[i], den[i], dng[i], db[i]);
      drain();
    end

    // Back-to-back with in_valid held high.
    for (int i = 1; i <= 3; i++) begin
      send(i, 1'b0, 1'b0, 0);
      b2b_chk = 1'b1;
    end
    b2b_chk = 1'b0;
    drain();

    // Backpressure: output held, new input ignored, single transfer on release.
    out_ready = 1'b0;
    send(100, 1'b0, 1'b0, 0);
    in_valid = 1'b0;
    for (int w = 0; w < 20 && !out_valid; w++) @(negedge clk);
    check("bp_valid_seen", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_n     = 12'd55;
      @(negedge clk);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_released_valid", int'(out_valid), 0);
    check("bp_released_ready", int'(in_ready), 1);
    check("bp_queue_empty", q.size(), 0);

    // Asynchronous reset mid-multiply discards the word.
    send(77, 1'b1, 1'b0, 2);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_code", int'(out_code), 0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_stale", int'(out_valid), 0);
    send(1, 1'b0, 1'b0, 0);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
    end
    drain();
    rdy_rand = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
